// File: rtl/ghr_ckpt_unit.sv
// Speculative global branch history register with an in-order checkpoint FIFO for mispredict recovery.
// Optional macro GHR_FOLD_EN adds hist_fold, an XOR fold of the history used for narrow table indexing.
module ghr_ckpt_unit #(
    parameter int HIST_WIDTH = 128,
    parameter int CKPT_DEPTH = 4,
    parameter int FOLD_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        spec_valid,
    input  logic                        spec_taken,
    output logic                        spec_ready,
    input  logic                        resolve_valid,
    input  logic                        resolve_mispredict,
    input  logic                        resolve_taken,
    input  logic                        load,
    input  logic [HIST_WIDTH-1:0]       load_data,
    output logic [HIST_WIDTH-1:0]       hist_out,
    output logic [$clog2(CKPT_DEPTH):0] ckpt_count,
`ifdef GHR_FOLD_EN
    output logic [FOLD_WIDTH-1:0]       hist_fold,
`endif
    output logic                        resolve_err
);

    localparam int PW = $clog2(CKPT_DEPTH);
    localparam int CW = PW + 1;

    logic [HIST_WIDTH-1:0] hist;
    logic [HIST_WIDTH-1:0] ckpt [CKPT_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic                  err_r;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;
    logic do_misp;
    logic do_err;

    // Handshake: a branch is taken on a clock edge only when spec_valid && spec_ready;
    // spec_valid with spec_ready low is dropped and the producer must hold and retry.
    // A full FIFO still accepts when a correct resolve frees the oldest slot this cycle.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(CKPT_DEPTH));
        spec_ready = !load && !(resolve_valid && resolve_mispredict) && (!full || resolve_valid);
        do_push    = spec_valid && spec_ready;
        do_pop     = resolve_valid && !resolve_mispredict && !empty && !load;
        do_misp    = resolve_valid && resolve_mispredict && !empty && !load;
        do_err     = resolve_valid && empty && !load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= do_err;
            if (load) begin
                hist  <= load_data;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (do_misp) begin
                // Rebuild from the history seen before the oldest branch, using its real outcome.
                hist  <= {ckpt[head][HIST_WIDTH-2:0], resolve_taken};
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    hist <= {hist[HIST_WIDTH-2:0], spec_taken};
                    tail <= tail + PW'(1);
                end
                if (do_pop) begin
                    head <= head + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Checkpoint storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            ckpt[tail] <= hist;
        end
    end

    assign hist_out    = hist;
    assign ckpt_count  = count;
    assign resolve_err = err_r;

`ifdef GHR_FOLD_EN
    localparam int NSLICE = (HIST_WIDTH + FOLD_WIDTH - 1) / FOLD_WIDTH;

    logic [NSLICE*FOLD_WIDTH-1:0] hist_pad;

    always_comb begin
        hist_pad  = (NSLICE*FOLD_WIDTH)'(hist);
        hist_fold = '0;
        for (int i = 0; i < NSLICE; i++) begin
            hist_fold = hist_fold ^ hist_pad[i*FOLD_WIDTH +: FOLD_WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_ghr_ckpt_unit.sv
// Directed plus random bench for ghr_ckpt_unit; a queue-based reference model feeds a scoreboard.
module tb_ghr_ckpt_unit;

    localparam int HW = 128;
    localparam int D  = 4;
    localparam int FW = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          spec_valid, spec_taken, spec_ready;
    logic          resolve_valid, resolve_mispredict, resolve_taken;
    logic          load;
    logic [HW-1:0] load_data;
    logic [HW-1:0] hist_out;
    logic [CW-1:0] ckpt_count;
    logic          resolve_err;
`ifdef GHR_FOLD_EN
    logic [FW-1:0] hist_fold;
`endif

    ghr_ckpt_unit #(.HIST_WIDTH(HW), .CKPT_DEPTH(D), .FOLD_WIDTH(FW)) dut (
        .clk                (clk),
        .reset              (reset),
        .spec_valid         (spec_valid),
        .spec_taken         (spec_taken),
        .spec_ready         (spec_ready),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .resolve_taken      (resolve_taken),
        .load               (load),
        .load_data          (load_data),
        .hist_out           (hist_out),
        .ckpt_count         (ckpt_count),
`ifdef GHR_FOLD_EN
        .hist_fold          (hist_fold),
`endif
        .resolve_err        (resolve_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [HW-1:0] m_hist;
    logic [HW-1:0] m_ck[$];

    // Scoreboard queues: expected post-edge values, pushed when stimulus is driven
    logic [HW-1:0] exp_q[$];
    logic [CW-1:0] cnt_q[$];
    logic          err_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready(input logic rv, input logic rm, input logic ld);
        return !ld && !(rv && rm) && ((m_ck.size() < D) || rv);
    endfunction

    // One clock: drive at negedge, check spec_ready, run the model, then compare after the edge.
    task automatic step(input logic rst, input logic sv, input logic st, input logic rv,
                        input logic rm, input logic rt, input logic ld, input logic [HW-1:0] ldata);
        logic rdy;
        logic err;
        @(negedge clk);
        reset = rst; spec_valid = sv; spec_taken = st;
        resolve_valid = rv; resolve_mispredict = rm; resolve_taken = rt;
        load = ld; load_data = ldata;
        #1;
        rdy = m_ready(rv, rm, ld);
        if (!rst) chk("spec_ready", HW'(spec_ready), HW'(rdy));
        err = 1'b0;
        if (rst) begin
            m_hist = '0;
            m_ck.delete();
        end else if (ld) begin
            m_hist = ldata;
            m_ck.delete();
        end else begin
            err = rv && (m_ck.size() == 0);
            if (rv && rm && m_ck.size() > 0) begin
                m_hist = {m_ck[0][HW-2:0], rt};
                m_ck.delete();
            end else begin
                if (rv && !rm && m_ck.size() > 0) void'(m_ck.pop_front());
                if (sv && rdy) begin
                    m_ck.push_back(m_hist);
                    m_hist = {m_hist[HW-2:0], st};
                end
            end
        end
        exp_q.push_back(m_hist);
        cnt_q.push_back(CW'(m_ck.size()));
        err_q.push_back(err);
        @(posedge clk);
        #1;
        chk("hist_out", hist_out, exp_q.pop_front());
        chk("ckpt_count", HW'(ckpt_count), HW'(cnt_q.pop_front()));
        chk("resolve_err", HW'(resolve_err), HW'(err_q.pop_front()));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push(input logic t);
        step(1'b0, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        m_hist = '0;
        reset = 1'b1; spec_valid = 1'b0; spec_taken = 1'b0;
        resolve_valid = 1'b0; resolve_mispredict = 1'b0; resolve_taken = 1'b0;
        load = 1'b0; load_data = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        chk("reset_hist", hist_out, '0);

        // Three pushes: taken, taken, not-taken
        push(1'b1); push(1'b1); push(1'b0);
        chk("ttn_hist", hist_out, HW'(128'h6));
        chk("ttn_count", HW'(ckpt_count), HW'(3));

        // Fill, blocked push dropped, then push with same-cycle correct resolve
        push(1'b1);
        chk("full_ready", HW'(spec_ready), HW'(0));
        push(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("full_pushpop_count", HW'(ckpt_count), HW'(4));
        chk("full_pushpop_hist", hist_out, HW'(128'h1B));

        // Drain with correct resolves, then resolve on empty
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("empty_err", HW'(resolve_err), HW'(1));
        idle();
        chk("empty_err_drop", HW'(resolve_err), HW'(0));

        // Mispredict recovery with same-cycle spec_valid ignored
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HW'(128'h5));
        push(1'b1); push(1'b1);
        chk("pre_misp_hist", hist_out, HW'(128'h17));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("misp_hist", hist_out, HW'(128'hA));
        chk("misp_count", HW'(ckpt_count), HW'(0));

        // Load wins over same-cycle spec and resolve
        push(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, HW'(128'hDEAD));
        chk("load_hist", hist_out, HW'(128'hDEAD));
        chk("load_count", HW'(ckpt_count), HW'(0));

`ifdef GHR_FOLD_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HW'(128'h12F0));
        chk("fold", HW'(hist_fold), HW'(8'hE2));
`endif

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 HW'({$urandom, $urandom, $urandom, $urandom}));
        end

        // Reset mid-stream
        push(1'b1); push(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("midreset_hist", hist_out, '0);
        chk("midreset_count", HW'(ckpt_count), HW'(0));
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
